// File: rtl/pio_out_blink_pulse.sv
// pio_out_blink_pulse: Avalon-MM output PIO with set/clear/toggle writes, per-bit blinking and one-shot pulses; ports clk, reset_n, address, chipselect, write_n, writedata, readdata (comb, zero-extended), out_port
module pio_out_blink_pulse #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int CNT_WIDTH = 24,
  parameter int PULSE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);
  localparam int PW = $clog2(PULSE_LEN + 1);
  logic [DATA_WIDTH-1:0] data, mask, pbits, w, data_nxt;
  logic [CNT_WIDTH-1:0] period, counter;
  logic [PW-1:0] pcnt;
  logic phase, wr;
  assign wr = chipselect && !write_n;
  assign w = writedata[DATA_WIDTH-1:0];
  always_comb begin
    data_nxt = !wr ? data :
               address == 3'd0 ? w :
               address == 3'd4 ? data | w :
               address == 3'd5 ? data & ~w :
               address == 3'd6 ? data ^ w : data;
    readdata = address == 3'd0 ? 32'(data) :
               address == 3'd1 ? 32'(mask) :
               address == 3'd2 ? 32'(period) :
               address == 3'd3 ? {30'b0, pcnt != '0, phase} : 32'b0;
  end
  assign out_port = (data & ~mask) | (data & mask & {DATA_WIDTH{phase}}) | pbits;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data    <= RESET_VALUE;
      mask    <= '0;
      period  <= '0;
      counter <= '0;
      phase   <= 1'b1;
      pbits   <= '0;
      pcnt    <= '0;
    end else begin
      data <= data_nxt;
      if (wr && address == 3'd1) mask <= w;
      if (wr && address == 3'd2) begin
        period  <= writedata[CNT_WIDTH-1:0];
        counter <= '0;
        phase   <= 1'b1;
      end else if (period == '0) begin
        counter <= '0;
        phase   <= 1'b1;
      end else if (counter == period) begin
        counter <= '0;
        phase   <= ~phase;
      end else begin
        counter <= counter + CNT_WIDTH'(1);
      end
      if (wr && address == 3'd7 && w != '0) begin
        pbits <= pbits | w;
        pcnt  <= PW'(PULSE_LEN);
      end else if (pcnt != '0) begin
        pcnt <= pcnt - PW'(1);
        if (pcnt == PW'(1)) pbits <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pio_out_blink_pulse.sv
// tb_pio_out_blink_pulse: directed self-checking bench for pio_out_blink_pulse
module tb_pio_out_blink_pulse;
  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] address;
  logic chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic [7:0] out_port;
  int n_cmp = 0;
  int n_bad = 0;

  pio_out_blink_pulse #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .CNT_WIDTH(24), .PULSE_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL reset_during out_port=%h exp=a5", out_port); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL reset_after out_port=%h exp=a5", out_port); end
    n_cmp++; if (readdata !== 32'h000000A5) begin n_bad++; $display("FAIL reset_rd0 readdata=%h exp=000000a5", readdata); end
    address = 3'd3; #1;
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL reset_rd3 readdata=%h exp=00000001", readdata); end
    address = 3'd2; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_rd2 readdata=%h exp=0", readdata); end
  endtask

  task automatic test_writes();
    wr(3'd0, 32'h0F);
    n_cmp++; if (out_port !== 8'h0F) begin n_bad++; $display("FAIL wr_data out_port=%h exp=0f", out_port); end
    wr(3'd4, 32'h30);
    n_cmp++; if (out_port !== 8'h3F) begin n_bad++; $display("FAIL wr_set out_port=%h exp=3f", out_port); end
    wr(3'd5, 32'h03);
    n_cmp++; if (out_port !== 8'h3C) begin n_bad++; $display("FAIL wr_clear out_port=%h exp=3c", out_port); end
    wr(3'd6, 32'hFF);
    n_cmp++; if (out_port !== 8'hC3) begin n_bad++; $display("FAIL wr_toggle out_port=%h exp=c3", out_port); end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #1;
      n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL rd_wo addr=%0d readdata=%h exp=0", a, readdata); end
    end
    address = 3'd0; #1;
    n_cmp++; if (readdata !== 32'hC3) begin n_bad++; $display("FAIL rd_data readdata=%h exp=c3", readdata); end
  endtask

  task automatic test_blink();
    logic ph;
    wr(3'd1, 32'h01);
    wr(3'd0, 32'h01);
    n_cmp++; if (out_port !== 8'h01) begin n_bad++; $display("FAIL blink_pre out_port=%h exp=01", out_port); end
    wr(3'd2, 32'd2);
    address = 3'd3; #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      ph = ((k / 3) % 2) == 0;
      n_cmp++; if (out_port !== {7'b0, ph}) begin n_bad++; $display("FAIL blink_out k=%0d out_port=%h exp=%h", k, out_port, {7'b0, ph}); end
      n_cmp++; if (readdata !== {31'b0, ph}) begin n_bad++; $display("FAIL blink_status k=%0d readdata=%h exp=%h", k, readdata, {31'b0, ph}); end
    end
    wr(3'd2, 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++; if (out_port !== 8'h01) begin n_bad++; $display("FAIL blink_off k=%0d out_port=%h exp=01", k, out_port); end
    end
    wr(3'd1, 32'h00);
  endtask

  task automatic test_pulse();
    wr(3'd0, 32'h00);
    wr(3'd7, 32'h80);
    address = 3'd3; #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++; if (out_port !== (k < 4 ? 8'h80 : 8'h00)) begin n_bad++; $display("FAIL pulse_out k=%0d out_port=%h", k, out_port); end
      n_cmp++; if (readdata !== (k < 4 ? 32'h3 : 32'h1)) begin n_bad++; $display("FAIL pulse_status k=%0d readdata=%h", k, readdata); end
    end
    wr(3'd7, 32'h80);
    @(posedge clk); #1;
    n_cmp++; if (out_port !== 8'h80) begin n_bad++; $display("FAIL pulse2_first out_port=%h exp=80", out_port); end
    wr(3'd7, 32'h01);
    address = 3'd3; #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_cmp++; if (out_port !== (k < 4 ? 8'h81 : 8'h00)) begin n_bad++; $display("FAIL pulse_restart k=%0d out_port=%h", k, out_port); end
    end
    wr(3'd7, 32'h00);
    address = 3'd3; #1;
    n_cmp++; if (out_port !== 8'h00) begin n_bad++; $display("FAIL pulse_zero out_port=%h exp=00", out_port); end
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL pulse_zero_status readdata=%h exp=1", readdata); end
  endtask

  task automatic test_async_reset();
    wr(3'd0, 32'h01);
    wr(3'd1, 32'h01);
    wr(3'd2, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_port !== 8'h00) begin n_bad++; $display("FAIL ar_blink_low out_port=%h exp=00", out_port); end
    wr(3'd7, 32'h40);
    n_cmp++; if (out_port !== 8'h40) begin n_bad++; $display("FAIL ar_pulse out_port=%h exp=40", out_port); end
    #2 reset_n = 1'b0;
    address = 3'd3; #1;
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL ar_out out_port=%h exp=a5", out_port); end
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL ar_status readdata=%h exp=1", readdata); end
    address = 3'd1; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL ar_mask readdata=%h exp=0", readdata); end
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL ar_after out_port=%h exp=a5", out_port); end
  endtask

  task automatic test_cs_gate();
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      address = 3'(a); writedata = 32'hFF; chipselect = 1'b0; write_n = 1'b0;
      @(posedge clk); #1;
      write_n = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_port !== 8'hA5) begin n_bad++; $display("FAIL cs_out out_port=%h exp=a5", out_port); end
    address = 3'd1; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL cs_mask readdata=%h exp=0", readdata); end
    address = 3'd2; #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL cs_period readdata=%h exp=0", readdata); end
    address = 3'd3; #1;
    n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL cs_status readdata=%h exp=1", readdata); end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_blink();
    test_pulse();
    test_async_reset();
    test_cs_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
